// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo : UART transmitter with transmit FIFO and valid/ready byte input
// Revision     : 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_BITS-1:0]                 tx_data,
   input  logic                                 tx_valid,
   output logic                                 tx_ready,
   output logic                                 tx,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int NW  = $clog2(DATA_BITS + 1);

   localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);
   localparam logic [NW-1:0]  DATA_LAST = NW'(DATA_BITS - 1);
   localparam logic [NW-1:0]  STOP_LAST = NW'(STOP_BITS - 1);
   localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count_next;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   logic [2:0]           state;
   logic [BCW-1:0]       baud_cnt;
   logic [NW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;

   logic                 push;
   logic                 pop;
   logic                 baud_last;
   logic                 stop_done;
   logic                 going_idle;

   assign head     = mem[rd_ptr];
   assign head_par = (PARITY == 1) ? ~^head : ^head;

   always_comb begin
      push       = tx_valid && tx_ready;
      baud_last  = (baud_cnt == BAUD_LAST);
      stop_done  = (state == S_STOP) && baud_last && (bit_cnt == STOP_LAST);
      // A new frame is launched either from idle or straight out of the last stop bit
      pop        = (fifo_count != '0) && ((state == S_IDLE) || stop_done);
      going_idle = ((state == S_IDLE) || stop_done) && !pop;
      count_next = fifo_count;
      if (push && !pop) begin
         count_next = fifo_count + CW'(1);
      end else if (!push && pop) begin
         count_next = fifo_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_count <= count_next;
         tx_ready   <= (count_next != FULL_CNT);
         busy       <= !going_idle || (count_next != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  shreg    <= head;
                  par_bit  <= head_par;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shreg[0];
                  shreg    <= shreg >> 1;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BCW'(1);
               end
            end
            S_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (PARITY != 0) begin
                        tx    <= par_bit;
                        state <= S_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + NW'(1);
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BCW'(1);
               end
            end
            S_PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= 1'b1;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + BCW'(1);
               end
            end
            S_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     if (pop) begin
                        shreg   <= head;
                        par_bit <= head_par;
                        tx      <= 1'b0;
                        state   <= S_START;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + NW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + BCW'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
